// File: rtl/key_event_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// key_event_conditioner_pkg
//   Shared definitions for the two-button key event conditioner:
//   - chan_state_t : per-channel debounce FSM state encoding (2 bits)
//   - DEBOUNCE_CYCLES_DEFAULT / LONG_PRESS_CYCLES_DEFAULT : parameter defaults
//     (20 ms and 3 s at CLK_HZ)
//   - CLK_HZ : nominal system clock frequency
//   - count_reached() : "one more sample reaches the target" test done in
//     33 bits so the 32-bit counters are never allowed to wrap.
// -----------------------------------------------------------------------------
package key_event_conditioner_pkg;

  localparam int unsigned CLK_HZ = 100000000;

  localparam logic [31:0] DEBOUNCE_CYCLES_DEFAULT   = 32'd2000000;
  localparam logic [31:0] LONG_PRESS_CYCLES_DEFAULT = 32'd300000000;

  typedef enum logic [1:0] {
    ST_RELEASED   = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_PRESSED    = 2'd2,
    ST_RELEASE_DB = 2'd3
  } chan_state_t;

  // True when the sample being taken now is the target-th consecutive one.
  // A target of 0 behaves like 1 (accept on the first sample).
  function automatic logic count_reached(input logic [31:0] count,
                                         input logic [31:0] target);
    return ({1'b0, count} + 33'd1) >= {1'b0, target};
  endfunction

endpackage

// File: rtl/key_event_conditioner_if.sv
// -----------------------------------------------------------------------------
// key_event_conditioner_if
//   Bundles the button inputs and the conditioned key event outputs.
//   There is no valid/ready handshake on this bus: every *_key / *_long signal
//   is a registered single-cycle strobe that is sampled on the rising clock
//   edge and cannot be back-pressured; *_level signals are plain levels.
//
//   Signals:
//     left_raw, right_raw     : asynchronous bouncing buttons, 1 = pressed
//     left_key, right_key     : one-cycle accepted-press strobes
//     both_key                : one-cycle strobe when both presses coincide
//     left_long, right_long   : one-cycle long-press strobes
//     left_level, right_level : debounced button levels
//     left_state, right_state : debug view of each channel FSM state
//
//   Modports:
//     master : the button/consumer side (drives raw inputs)
//     slave  : the conditioner (drives events, levels, debug state)
// -----------------------------------------------------------------------------
interface key_event_conditioner_if;
  import key_event_conditioner_pkg::*;

  logic        left_raw;
  logic        right_raw;
  logic        left_key;
  logic        right_key;
  logic        both_key;
  logic        left_long;
  logic        right_long;
  logic        left_level;
  logic        right_level;
  chan_state_t left_state;
  chan_state_t right_state;

  modport master (
    output left_raw, right_raw,
    input  left_key, right_key, both_key, left_long, right_long,
    input  left_level, right_level, left_state, right_state
  );

  modport slave (
    input  left_raw, right_raw,
    output left_key, right_key, both_key, left_long, right_long,
    output left_level, right_level, left_state, right_state
  );

endinterface

// File: rtl/key_event_conditioner_debounce_channel.sv
// -----------------------------------------------------------------------------
// key_debounce_channel
//   One button channel: 2-flop synchronizer, debounce FSM
//   (RELEASED / PRESS_DB / PRESSED / RELEASE_DB), debounce counter and
//   long-press hold counter.
//
//   Ports:
//     clk, reset  : system clock, synchronous active-high reset
//     raw         : asynchronous bouncing button, 1 = pressed
//     level       : debounced level (high in PRESSED and RELEASE_DB)
//     press       : combinational strobe, high in the cycle the FSM accepts
//                   a press (registered by the parent)
//     long_press  : combinational strobe, high in the cycle the hold counter
//                   reaches LONG_PRESS_CYCLES (registered by the parent)
//     state       : debug view of the FSM state register
//
//   Timing: a clean raw edge reaches sync_q two cycles later; that sample is
//   the first of the DEBOUNCE_CYCLES consecutive samples, so the parent's
//   registered pulse appears 2 + DEBOUNCE_CYCLES cycles after the raw edge.
// -----------------------------------------------------------------------------
module key_debounce_channel
  import key_event_conditioner_pkg::*;
#(
  parameter logic [31:0] DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEFAULT,
  parameter logic [31:0] LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        raw,
  output logic        level,
  output logic        press,
  output logic        long_press,
  output chan_state_t state
);

  logic        sync_meta;
  logic        sync_q;
  chan_state_t state_q;
  chan_state_t state_d;
  logic [31:0] db_cnt_q;
  logic [31:0] db_cnt_d;
  logic [31:0] hold_cnt_q;
  logic [31:0] hold_cnt_d;

  // Synchronizer: nothing else in the channel looks at raw directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync_q    <= sync_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RELEASED;
      db_cnt_q   <= 32'd0;
      hold_cnt_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    press      = 1'b0;
    long_press = 1'b0;

    case (state_q)
      ST_RELEASED: begin
        db_cnt_d   = 32'd0;
        hold_cnt_d = 32'd0;
        if (sync_q) begin
          // This sample already counts as the first stable high.
          if (count_reached(32'd0, DEBOUNCE_CYCLES)) begin
            state_d = ST_PRESSED;
            press   = 1'b1;
          end else begin
            state_d  = ST_PRESS_DB;
            db_cnt_d = 32'd1;
          end
        end
      end

      ST_PRESS_DB: begin
        if (!sync_q) begin
          state_d  = ST_RELEASED;
          db_cnt_d = 32'd0;
        end else if (count_reached(db_cnt_q, DEBOUNCE_CYCLES)) begin
          state_d  = ST_PRESSED;
          db_cnt_d = 32'd0;
          press    = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 32'd1;
        end
      end

      ST_PRESSED: begin
        // Hold counter saturates at LONG_PRESS_CYCLES, so the strobe can
        // only fire once per press.
        if (hold_cnt_q < LONG_PRESS_CYCLES) begin
          hold_cnt_d = hold_cnt_q + 32'd1;
          if (hold_cnt_q + 32'd1 == LONG_PRESS_CYCLES) begin
            long_press = 1'b1;
          end
        end
        if (!sync_q) begin
          if (count_reached(32'd0, DEBOUNCE_CYCLES)) begin
            state_d    = ST_RELEASED;
            db_cnt_d   = 32'd0;
            hold_cnt_d = 32'd0;
          end else begin
            state_d  = ST_RELEASE_DB;
            db_cnt_d = 32'd1;
          end
        end
      end

      ST_RELEASE_DB: begin
        // Hold counter is frozen here so a short glitch does not restart
        // the long-press timing.
        if (sync_q) begin
          state_d  = ST_PRESSED;
          db_cnt_d = 32'd0;
        end else if (count_reached(db_cnt_q, DEBOUNCE_CYCLES)) begin
          state_d    = ST_RELEASED;
          db_cnt_d   = 32'd0;
          hold_cnt_d = 32'd0;
        end else begin
          db_cnt_d = db_cnt_q + 32'd1;
        end
      end

      default: begin
        state_d    = ST_RELEASED;
        db_cnt_d   = 32'd0;
        hold_cnt_d = 32'd0;
      end
    endcase
  end

  assign level = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_DB);
  assign state = state_q;

endmodule

// File: rtl/key_event_conditioner.sv
// -----------------------------------------------------------------------------
// key_event_conditioner
//   Two-button front end for the gesture power controller. Each button is
//   synchronized and debounced by its own key_debounce_channel; this level
//   merges coincident presses into both_key and registers all strobes.
//
//   Ports:
//     clk   : 100 MHz system clock, all logic on its rising edge
//     reset : synchronous, active-high
//     keys  : key_event_conditioner_if.slave (raw buttons in; key/long
//             strobes, debounced levels and channel debug state out)
//
//   Parameters:
//     DEBOUNCE_CYCLES   : stable samples needed to accept a level change
//     LONG_PRESS_CYCLES : debounced-high hold count that signals a long press
// -----------------------------------------------------------------------------
module key_event_conditioner
  import key_event_conditioner_pkg::*;
#(
  parameter logic [31:0] DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEFAULT,
  parameter logic [31:0] LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  key_event_conditioner_if.slave  keys
);

  logic        left_press;
  logic        right_press;
  logic        left_long_press;
  logic        right_long_press;
  logic        left_level;
  logic        right_level;
  chan_state_t left_state;
  chan_state_t right_state;

  logic        left_key_q;
  logic        right_key_q;
  logic        both_key_q;
  logic        left_long_q;
  logic        right_long_q;

  key_debounce_channel #(
    .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
    .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES)
  ) u_left (
    .clk        (clk),
    .reset      (reset),
    .raw        (keys.left_raw),
    .level      (left_level),
    .press      (left_press),
    .long_press (left_long_press),
    .state      (left_state)
  );

  key_debounce_channel #(
    .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
    .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES)
  ) u_right (
    .clk        (clk),
    .reset      (reset),
    .raw        (keys.right_raw),
    .level      (right_level),
    .press      (right_press),
    .long_press (right_long_press),
    .state      (right_state)
  );

  // Same-cycle presses collapse into both_key only; long presses are never
  // merged and pass through independently.
  always_ff @(posedge clk) begin
    if (reset) begin
      left_key_q   <= 1'b0;
      right_key_q  <= 1'b0;
      both_key_q   <= 1'b0;
      left_long_q  <= 1'b0;
      right_long_q <= 1'b0;
    end else begin
      left_key_q   <= left_press & ~right_press;
      right_key_q  <= right_press & ~left_press;
      both_key_q   <= left_press & right_press;
      left_long_q  <= left_long_press;
      right_long_q <= right_long_press;
    end
  end

  assign keys.left_key    = left_key_q;
  assign keys.right_key   = right_key_q;
  assign keys.both_key    = both_key_q;
  assign keys.left_long   = left_long_q;
  assign keys.right_long  = right_long_q;
  assign keys.left_level  = left_level;
  assign keys.right_level = right_level;
  assign keys.left_state  = left_state;
  assign keys.right_state = right_state;

endmodule

// File: doc/key_event_conditioner.md
KEY_EVENT_CONDITIONER -- requirements
Module: key_event_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 32'd2000000, meaning stable-sample count required to accept a level change (20 ms at 100 MHz).
REQ-002 SHALL have parameter LONG_PRESS_CYCLES, default 32'd300000000, meaning debounced-high hold count that signals a long press (3 s at 100 MHz).
REQ-003 SHALL have port clk, input, 1 bit: the single 100 MHz system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port left_raw, input, 1 bit: asynchronous, bouncing left button, high = pressed.
REQ-006 SHALL have port right_raw, input, 1 bit: asynchronous, bouncing right button, high = pressed.
REQ-007 SHALL have port left_key, output, 1 bit: single-cycle pulse for an accepted left press, feeding the gesture power controller.
REQ-008 SHALL have port right_key, output, 1 bit: single-cycle pulse for an accepted right press.
REQ-009 SHALL have port both_key, output, 1 bit: single-cycle pulse when left and right presses are accepted in the same cycle.
REQ-010 SHALL have port left_long, output, 1 bit: single-cycle long-press pulse for left.
REQ-011 SHALL have port right_long, output, 1 bit: single-cycle long-press pulse for right.
REQ-012 SHALL have port left_level, output, 1 bit: debounced left level.
REQ-013 SHALL have port right_level, output, 1 bit: debounced right level.

Function
REQ-014 SHALL pass each raw input through a 2-flop synchronizer before any other use.
REQ-015 SHALL implement, per channel, the states RELEASED, PRESS_DB, PRESSED and RELEASE_DB.
REQ-016 RELEASED -> PRESS_DB when the synchronized input is 1; PRESS_DB -> RELEASED on any 0 sample, which clears the counter.
REQ-017 PRESS_DB -> PRESSED after DEBOUNCE_CYCLES consecutive 1 samples; on this transition *_level sets and the press pulse fires for exactly 1 cycle.
REQ-018 Raw-to-press-pulse latency SHALL be exactly 2 + DEBOUNCE_CYCLES cycles for a clean edge.
REQ-019 PRESSED -> RELEASE_DB on a 0 sample; RELEASE_DB -> PRESSED on a 1 sample; RELEASE_DB -> RELEASED after DEBOUNCE_CYCLES consecutive 0 samples, which clears *_level; release produces no pulse.
REQ-020 In PRESSED, a hold counter SHALL increment each cycle; when it reaches LONG_PRESS_CYCLES, *_long pulses for 1 cycle, and the counter then saturates with no repeat pulse until the next press.
REQ-021 The hold counter SHALL keep its value through RELEASE_DB and clear on entry to RELEASED.
REQ-022 If left and right press pulses coincide, both_key SHALL be 1 and left_key/right_key SHALL be 0 that cycle; presses one or more cycles apart give individual pulses.
REQ-023 Long-press pulses SHALL never be merged: coincident long presses raise left_long and right_long together.
REQ-024 All counters SHALL be 32 bits unsigned and never wrap.
REQ-025 Pulse outputs SHALL be registered, with at most one pulse per output per press.

Reset
REQ-026 Reset SHALL return all outputs to 0, both channels to RELEASED, all counters to 0 and synchronizer flops to 0.
REQ-027 Reset asserted mid-press SHALL discard the press; after reset deasserts with the button still held, a fresh full debounce SHALL run and produce one press pulse.

Structure
REQ-028 A shared package SHALL hold the channel state encoding (2 bits), the DEBOUNCE_CYCLES/LONG_PRESS_CYCLES defaults and CLK_HZ = 100000000.
REQ-029 SHALL contain one sub-module, key_debounce_channel (synchronizer + FSM + counters, outputs level/press/long), instantiated twice; the top holds only the coincidence merge and output registers.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20)
REQ-030 left_raw clean rise at cycle 10 -> left_key high only in cycle 16, left_level high from cycle 16.
REQ-031 right_raw toggling 1,0,1,0 each cycle, then held 1 -> no pulse during bounce; exactly one right_key 6 cycles after the final rise.
REQ-032 Both raws rise in the same cycle -> one both_key pulse, left_key=right_key=0; with right lagging 1 cycle -> left_key, then right_key the next cycle.
REQ-033 left held 40 cycles -> one left_key, then one left_long 20 cycles later, no repeat; release -> level drops after 4 stable lows.
REQ-034 left held with a 2-cycle low glitch during PRESSED -> no extra left_key, left_level stays 1, long count continues.
REQ-035 reset pulsed while right held in PRESSED -> outputs 0; after deassert, one new right_key 6 cycles later.
